gpu_operand_collector: RTL and testbench

Operand collector sitting directly upstream of the per-warp register bank array. It accepts one decoded instruction at a time (warp, up to three source registers, opaque tag) and schedules bank reads so each bank serves at most one read per cycle. It gathers the 32-lane operand vectors and presents a complete operand set to the execute stage over a valid/ready handshake.

---
 rtl/gpu_pkg.sv | 26 ++
 rtl/gpu_bank_arbiter.sv | 30 +++
 rtl/gpu_operand_collector.sv | 146 ++++++++++++++
 tb/tb_gpu_operand_collector.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: default sizes, collector state encoding and the
// register-bank mapping that both the collector and the bank array agree on.
package gpu_pkg;

    localparam int unsigned DEF_NUM_WARPS = 4;
    localparam int unsigned DEF_NUM_BANKS = 4;
    localparam int unsigned DEF_NUM_REGS  = 32;
    localparam int unsigned DEF_LANES     = 32;
    localparam int unsigned DEF_DATA_W    = 64;
    localparam int unsigned DEF_TAG_W     = 16;
    localparam int unsigned NUM_SRCS      = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_ISSUE   = 2'd2
    } oc_state_e;

    // Warp-skewed interleave; nbanks is a power of two so this is the low bits of the sum.
    function automatic int unsigned bank_map(input int unsigned warp,
                                             input int unsigned regn,
                                             input int unsigned nbanks);
        return (warp + regn) & (nbanks - 1);
    endfunction

endpackage

// File: rtl/gpu_bank_arbiter.sv
// Per-bank fixed-priority grant: each bank serves the lowest-numbered pending
// source that maps to it.
module gpu_bank_arbiter
    import gpu_pkg::*;
#(
    parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
    input  logic [NUM_SRCS-1:0]           pending,
    input  logic [NUM_SRCS*BANK_W-1:0]    src_bank,
    output logic [NUM_BANKS*NUM_SRCS-1:0] grant
);

    logic taken;

    always_comb begin
        grant = '0;
        taken = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            taken = 1'b0;
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (!taken && pending[s] && (src_bank[s*BANK_W +: BANK_W] == BANK_W'(b))) begin
                    grant[b*NUM_SRCS + s] = 1'b1;
                    taken = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/gpu_operand_collector.sv
// Operand collector: schedules conflict-free bank reads for one instruction at a
// time, gathers the operand vectors and hands the set to execute.
module gpu_operand_collector
    import gpu_pkg::*;
#(
    parameter  int unsigned NUM_WARPS = DEF_NUM_WARPS,
    parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
    parameter  int unsigned NUM_REGS  = DEF_NUM_REGS,
    parameter  int unsigned LANES     = DEF_LANES,
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned TAG_W     = DEF_TAG_W,
    localparam int unsigned WARP_W    = $clog2(NUM_WARPS),
    localparam int unsigned REG_W     = $clog2(NUM_REGS),
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS),
    localparam int unsigned VEC_W     = LANES * DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WARP_W-1:0]           in_warp,
    input  logic [NUM_SRCS-1:0]         in_src_valid,
    input  logic [REG_W-1:0]            in_src0,
    input  logic [REG_W-1:0]            in_src1,
    input  logic [REG_W-1:0]            in_src2,
    input  logic [TAG_W-1:0]            in_tag,
    output logic [NUM_BANKS-1:0]        bank_rd_en,
    output logic [NUM_BANKS*WARP_W-1:0] bank_rd_warp,
    output logic [NUM_BANKS*REG_W-1:0]  bank_rd_reg,
    input  logic [NUM_BANKS*VEC_W-1:0]  bank_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WARP_W-1:0]           out_warp,
    output logic [TAG_W-1:0]            out_tag,
    output logic [NUM_SRCS-1:0]         out_src_valid,
    output logic [VEC_W-1:0]            out_op0,
    output logic [VEC_W-1:0]            out_op1,
    output logic [VEC_W-1:0]            out_op2
);

    oc_state_e                       state, state_nx;
    logic [WARP_W-1:0]               warp_q;
    logic [NUM_SRCS-1:0][REG_W-1:0]  src_q;
    logic [NUM_SRCS-1:0][BANK_W-1:0] src_bank;
    logic [NUM_SRCS-1:0]             pending, inflight, rd_set, pend_act;
    logic [NUM_BANKS*NUM_SRCS-1:0]   grant;
    logic [NUM_SRCS-1:0][VEC_W-1:0]  op_q;
    logic                            accept;

    assign accept   = (state == ST_IDLE) && in_valid && in_ready;
    assign pend_act = (state == ST_COLLECT) ? pending : '0;

    always_comb begin
        src_bank = '0;
        for (int s = 0; s < NUM_SRCS; s++) begin
            src_bank[s] = BANK_W'(bank_map(32'(warp_q), 32'(src_q[s]), NUM_BANKS));
        end
    end

    gpu_bank_arbiter #(.NUM_BANKS(NUM_BANKS)) u_arb (
        .pending  (pend_act),
        .src_bank (src_bank),
        .grant    (grant)
    );

    // Drive bank ports from grants; a read also serves every pending source naming the same register.
    always_comb begin
        bank_rd_en   = '0;
        bank_rd_warp = '0;
        bank_rd_reg  = '0;
        rd_set       = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int s = 0; s < NUM_SRCS; s++) begin
                if (grant[b*NUM_SRCS + s]) begin
                    bank_rd_en[b]                   = 1'b1;
                    bank_rd_warp[b*WARP_W +: WARP_W] = warp_q;
                    bank_rd_reg[b*REG_W +: REG_W]   = src_q[s];
                    for (int k = 0; k < NUM_SRCS; k++) begin
                        if (pend_act[k] && (src_q[k] == src_q[s])) begin
                            rd_set[k] = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (accept) state_nx = (in_src_valid == '0) ? ST_ISSUE : ST_COLLECT;
            ST_COLLECT: if (pending == '0) state_nx = ST_ISSUE;
            ST_ISSUE:   if (out_valid && out_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Instruction latch, pending/inflight bookkeeping and operand capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready      <= 1'b0;
            out_valid     <= 1'b0;
            warp_q        <= '0;
            src_q         <= '0;
            out_tag       <= '0;
            out_src_valid <= '0;
            pending       <= '0;
            inflight      <= '0;
            op_q          <= '0;
        end else begin
            in_ready  <= (state_nx == ST_IDLE);
            out_valid <= (state_nx == ST_ISSUE);
            if (accept) begin
                warp_q        <= in_warp;
                src_q         <= {in_src2, in_src1, in_src0};
                out_tag       <= in_tag;
                out_src_valid <= in_src_valid;
                pending       <= in_src_valid;
                inflight      <= '0;
                op_q          <= '0;
            end else begin
                pending  <= pending & ~rd_set;
                inflight <= rd_set;
                for (int s = 0; s < NUM_SRCS; s++) begin
                    if (inflight[s]) begin
                        op_q[s] <= bank_rd_data[32'(src_bank[s])*VEC_W +: VEC_W];
                    end
                end
            end
        end
    end

    assign out_warp = warp_q;
    assign out_op0  = op_q[0];
    assign out_op1  = op_q[1];
    assign out_op2  = op_q[2];

endmodule

// File: tb/tb_gpu_operand_collector.sv
// Scoreboard bench for gpu_operand_collector with a one-cycle-latency bank model.
module tb_gpu_operand_collector;

    localparam int unsigned NB = 4, LN = 32, DW = 64, TW = 16;
    localparam int unsigned WW = 2, RW = 5, VW = LN * DW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WW-1:0]     in_warp = '0;
    logic [2:0]        in_src_valid = '0;
    logic [RW-1:0]     in_src0 = '0, in_src1 = '0, in_src2 = '0;
    logic [TW-1:0]     in_tag = '0;
    logic [NB-1:0]     bank_rd_en;
    logic [NB*WW-1:0]  bank_rd_warp;
    logic [NB*RW-1:0]  bank_rd_reg;
    logic [NB*VW-1:0]  bank_rd_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [WW-1:0]     out_warp;
    logic [TW-1:0]     out_tag;
    logic [2:0]        out_src_valid;
    logic [VW-1:0]     out_op0, out_op1, out_op2;

    always #5 clk = ~clk;

    gpu_operand_collector dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_warp(in_warp),
        .in_src_valid(in_src_valid), .in_src0(in_src0), .in_src1(in_src1),
        .in_src2(in_src2), .in_tag(in_tag),
        .bank_rd_en(bank_rd_en), .bank_rd_warp(bank_rd_warp),
        .bank_rd_reg(bank_rd_reg), .bank_rd_data(bank_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_warp(out_warp),
        .out_tag(out_tag), .out_src_valid(out_src_valid),
        .out_op0(out_op0), .out_op1(out_op1), .out_op2(out_op2)
    );

    typedef struct {
        logic [WW-1:0] warp;
        logic [TW-1:0] tag;
        logic [2:0]    mask;
        logic [VW-1:0] op0, op1, op2;
    } exp_t;

    exp_t          sb[$];
    int            tests = 0, fails = 0;
    int            cyc = 0;
    int            t_acc, hs_cyc, out_lat;
    logic [NB-1:0] en_log [32];
    logic [RW-1:0] reg_log [32][NB];
    logic [WW-1:0] nxt_w;
    logic [2:0]    nxt_m;
    logic [RW-1:0] nxt_s0, nxt_s1, nxt_s2;
    logic [TW-1:0] nxt_tag;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [VW-1:0] vec_of(input logic [WW-1:0] w, input logic [RW-1:0] r);
        logic [VW-1:0] v;
        for (int l = 0; l < LN; l++) v[l*DW +: DW] = {8'(w), 8'(r), 16'(l), 32'hC0DE_0000 ^ 32'(l * 97)};
        return v;
    endfunction

    function automatic int lane_diff(input logic [VW-1:0] a, input logic [VW-1:0] b);
        for (int l = 0; l < LN; l++) if (a[l*DW +: DW] !== b[l*DW +: DW]) return l;
        return 0;
    endfunction

    // Register bank model: data for the requested warp/reg one cycle after the strobe, ones otherwise.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            bank_rd_data[b*VW +: VW] <= bank_rd_en[b] ?
                vec_of(bank_rd_warp[b*WW +: WW], bank_rd_reg[b*RW +: RW]) : {VW{1'b1}};
    end

    task automatic send(input logic [WW-1:0] w, input logic [2:0] m, input logic [RW-1:0] s0,
                        input logic [RW-1:0] s1, input logic [RW-1:0] s2, input logic [TW-1:0] tag);
        exp_t e;
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL in_ready_wait: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_warp = w; in_src_valid = m;
        in_src0 = s0; in_src1 = s1; in_src2 = s2; in_tag = tag;
        t_acc = cyc;
        e.warp = w; e.tag = tag; e.mask = m;
        e.op0 = m[0] ? vec_of(w, s0) : '0;
        e.op1 = m[1] ? vec_of(w, s1) : '0;
        e.op2 = m[2] ? vec_of(w, s2) : '0;
        sb.push_back(e);
    endtask

    task automatic collect(input int stall, input bit hold);
        exp_t          e;
        logic [TW-1:0] s_tag;
        logic [VW-1:0] s_op0, s_op1;
        logic          bad;
        int            k = 0, l;
        out_lat = -1;
        for (int i = 0; i < 32; i++) begin
            en_log[i] = '0;
            for (int b = 0; b < NB; b++) reg_log[i][b] = '0;
        end
        out_ready = (stall == 0);
        while (out_lat < 0 && k < 24) begin
            @(negedge clk); k++;
            if (k == 1) begin
                if (hold) begin
                    in_warp = nxt_w; in_src_valid = nxt_m; in_src0 = nxt_s0;
                    in_src1 = nxt_s1; in_src2 = nxt_s2; in_tag = nxt_tag;
                end else in_valid = 1'b0;
            end
            en_log[k] = bank_rd_en;
            for (int b = 0; b < NB; b++) reg_log[k][b] = bank_rd_reg[b*RW +: RW];
            if (out_valid === 1'b1) out_lat = k;
            else begin
                bad = (in_ready !== 1'b0);
                for (int b = 0; b < NB; b++) begin
                    if (bank_rd_en[b])
                        bad |= ((int'(bank_rd_reg[b*RW +: RW]) + int'(bank_rd_warp[b*WW +: WW])) % 4) != b;
                    else
                        bad |= (bank_rd_reg[b*RW +: RW] !== '0) || (bank_rd_warp[b*WW +: WW] !== '0);
                end
                tests++;
                if (bad) begin
                    fails++;
                    $display("FAIL collect_bank offset %0d: en=%b warp=%h reg=%h in_ready=%b (required mapped reads, zero idle fields, in_ready 0)",
                             k, bank_rd_en, bank_rd_warp, bank_rd_reg, in_ready);
                end
            end
        end
        tests++;
        if (out_lat < 0) begin
            fails++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1 within 24 cycles", out_valid);
            if (sb.size() > 0) void'(sb.pop_front());
            out_ready = 1'b1;
            return;
        end
        s_tag = out_tag; s_op0 = out_op0; s_op1 = out_op1;
        for (int j = 0; j < stall; j++) begin
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_tag !== s_tag || out_op0 !== s_op0 ||
                out_op1 !== s_op1 || bank_rd_en !== '0) begin
                fails++;
                $display("FAIL stall_hold cycle %0d: out_valid=%b in_ready=%b tag=%h en=%b required 1/0/%h/0000 and stable ops",
                         j, out_valid, in_ready, out_tag, bank_rd_en, s_tag);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        hs_cyc = cyc;
        e = sb.pop_front();
        tests++;
        if (out_warp !== e.warp || out_tag !== e.tag || out_src_valid !== e.mask) begin
            fails++;
            $display("FAIL out_meta: warp=%h tag=%h mask=%b required %h %h %b",
                     out_warp, out_tag, out_src_valid, e.warp, e.tag, e.mask);
        end
        tests++;
        if (out_op0 !== e.op0) begin
            fails++; l = lane_diff(out_op0, e.op0);
            $display("FAIL out_op0 lane %0d: actual %h required %h", l, out_op0[l*DW +: DW], e.op0[l*DW +: DW]);
        end
        tests++;
        if (out_op1 !== e.op1) begin
            fails++; l = lane_diff(out_op1, e.op1);
            $display("FAIL out_op1 lane %0d: actual %h required %h", l, out_op1[l*DW +: DW], e.op1[l*DW +: DW]);
        end
        tests++;
        if (out_op2 !== e.op2) begin
            fails++; l = lane_diff(out_op2, e.op2);
            $display("FAIL out_op2 lane %0d: actual %h required %h", l, out_op2[l*DW +: DW], e.op2[l*DW +: DW]);
        end
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL out_valid_drop: out_valid=%b required 0 after handshake", out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || bank_rd_en !== '0 || out_tag !== '0 ||
            out_warp !== '0 || out_src_valid !== '0 || out_op0 !== '0 || out_op1 !== '0 || out_op2 !== '0) begin
            fails++;
            $display("FAIL reset_outputs: in_ready=%b out_valid=%b en=%b tag=%h required all 0",
                     in_ready, out_valid, bank_rd_en, out_tag);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_no_conflict();
        send(2'd1, 3'b111, 5'd0, 5'd1, 5'd2, 16'h1001);
        collect(0, 1'b0);
        tests++;
        if (out_lat != 3 || en_log[1] !== 4'b1110 || en_log[2] !== 4'b0000 ||
            reg_log[1][1] !== 5'd0 || reg_log[1][2] !== 5'd1 || reg_log[1][3] !== 5'd2) begin
            fails++;
            $display("FAIL no_conflict: lat=%0d en1=%b en2=%b required 3 1110 0000", out_lat, en_log[1], en_log[2]);
        end
    endtask

    task automatic test_same_bank();
        logic [RW-1:0] er [3];
        er[0] = 5'd0; er[1] = 5'd4; er[2] = 5'd8;
        send(2'd0, 3'b111, 5'd0, 5'd4, 5'd8, 16'h2002);
        collect(0, 1'b0);
        tests++;
        if (out_lat != 5 || en_log[4] !== 4'b0000) begin
            fails++;
            $display("FAIL same_bank_lat: lat=%0d en4=%b required 5 0000", out_lat, en_log[4]);
        end
        for (int k = 1; k <= 3; k++) begin
            tests++;
            if (en_log[k] !== 4'b0001 || reg_log[k][0] !== er[k-1]) begin
                fails++;
                $display("FAIL same_bank_read %0d: en=%b reg=%0d required 0001 r%0d", k, en_log[k], reg_log[k][0], er[k-1]);
            end
        end
    endtask

    task automatic test_duplicate();
        send(2'd2, 3'b011, 5'd5, 5'd5, 5'd13, 16'h3003);
        collect(0, 1'b0);
        tests++;
        if (out_lat != 3 || en_log[1] !== 4'b1000 || reg_log[1][3] !== 5'd5 || en_log[2] !== 4'b0000) begin
            fails++;
            $display("FAIL duplicate: lat=%0d en1=%b en2=%b required 3 1000 0000", out_lat, en_log[1], en_log[2]);
        end
    endtask

    task automatic test_empty_mask();
        send(2'd3, 3'b000, 5'd7, 5'd8, 5'd9, 16'hBEEF);
        collect(0, 1'b0);
        tests++;
        if (out_lat != 1 || en_log[1] !== 4'b0000) begin
            fails++;
            $display("FAIL empty_mask: lat=%0d en=%b required 1 0000", out_lat, en_log[1]);
        end
    endtask

    task automatic test_back_to_back();
        nxt_w = 2'd3; nxt_m = 3'b011; nxt_s0 = 5'd3; nxt_s1 = 5'd10; nxt_s2 = 5'd0; nxt_tag = 16'h1234;
        send(2'd1, 3'b111, 5'd4, 5'd5, 5'd6, 16'h4004);
        collect(5, 1'b1);
        tests++;
        if (out_lat != 3) begin
            fails++;
            $display("FAIL stall_lat: lat=%0d required 3", out_lat);
        end
        send(nxt_w, nxt_m, nxt_s0, nxt_s1, nxt_s2, nxt_tag);
        tests++;
        if (t_acc != hs_cyc + 1) begin
            fails++;
            $display("FAIL next_accept: accept cycle %0d required %0d", t_acc, hs_cyc + 1);
        end
        collect(0, 1'b0);
        tests++;
        if (out_lat != 3 || en_log[1] !== 4'b0110) begin
            fails++;
            $display("FAIL next_instr: lat=%0d en1=%b required 3 0110", out_lat, en_log[1]);
        end
    endtask

    task automatic test_reset_mid();
        send(2'd3, 3'b111, 5'd1, 5'd5, 5'd9, 16'h5005);
        void'(sb.pop_back());
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (bank_rd_en !== '0 || bank_rd_warp !== '0 || bank_rd_reg !== '0 || out_valid !== 1'b0 ||
            in_ready !== 1'b0 || out_tag !== '0 || out_warp !== '0 || out_src_valid !== '0 ||
            out_op0 !== '0 || out_op1 !== '0 || out_op2 !== '0) begin
            fails++;
            $display("FAIL reset_mid: en=%b out_valid=%b in_ready=%b tag=%h required all 0",
                     bank_rd_en, out_valid, in_ready, out_tag);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(2'd3, 3'b101, 5'd2, 5'd6, 5'd7, 16'h6006);
        collect(0, 1'b0);
        tests++;
        if (out_lat != 3 || en_log[1] !== 4'b0110) begin
            fails++;
            $display("FAIL after_reset: lat=%0d en1=%b required 3 0110", out_lat, en_log[1]);
        end
    endtask

    initial begin
        test_reset();
        test_no_conflict();
        test_same_bank();
        test_duplicate();
        test_empty_mask();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
